// File: rtl/bit_sync_pkg.sv
// ---------------------------------------------------------------------------
// bit_sync_pkg
// Shared constants for the bit_sync clock-domain-crossing synchronizer.
//   BIT_SYNC_DEF_STAGES : default number of flip-flop stages per bit
//   BIT_SYNC_DEF_WIDTH  : default number of independently synchronized bits
//   BIT_SYNC_MIN_STAGES : shortest chain that still gives a resolution stage
// No ports (package).
// ---------------------------------------------------------------------------
package bit_sync_pkg;

    localparam int BIT_SYNC_DEF_STAGES = 5;
    localparam int BIT_SYNC_DEF_WIDTH  = 6;
    localparam int BIT_SYNC_MIN_STAGES = 2;

    // True when a stage count / bus width pair describes a buildable synchronizer.
    function automatic bit bitSyncParamsLegal(input int stages, input int width);
        return (stages >= BIT_SYNC_MIN_STAGES) && (width >= 1);
    endfunction

endpackage : bit_sync_pkg

// File: rtl/bit_sync_sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
// Single-bit synchronizer: NUM_STAGES flip-flops in a plain shift chain, all
// cleared asynchronously by an active-low reset.
// Ports:
//   CLK  in   destination-domain clock, rising edge
//   RST  in   asynchronous active-low reset, clears every stage
//   d_i  in   asynchronous level input
//   q_o  out  synchronized output, taken straight from the last stage
// ---------------------------------------------------------------------------
module sync_chain
    import bit_sync_pkg::*;
#(
    parameter int NUM_STAGES = BIT_SYNC_DEF_STAGES
) (
    input  logic CLK,
    input  logic RST,
    input  logic d_i,
    output logic q_o
);

    // Tools must keep these flops adjacent and unretimed so the first stage
    // gets a full cycle to resolve metastability before the next samples it.
    (* async_reg = "true", dont_retime = "true" *)
    logic [NUM_STAGES-1:0] stage_q;
    logic [NUM_STAGES-1:0] stage_d;

    // Pure shift: the new sample enters at bit 0, nothing sits between stages.
    assign stage_d = {stage_q[NUM_STAGES-2:0], d_i};

    // Reset drops the whole chain to 0 without waiting for a clock edge,
    // discarding anything still in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q[NUM_STAGES-1];

endmodule : sync_chain

// File: rtl/bit_sync.sv
// ---------------------------------------------------------------------------
// bit_sync
// Multi-bit synchronizer: BUS_WIDTH independent sync_chain instances, each
// NUM_STAGES deep. Bits are not kept coherent with each other, so the input
// bus must be single-bit, quasi-static or Gray-coded.
// Ports:
//   CLK    in   destination-domain clock, rising edge
//   RST    in   asynchronous active-low reset, clears all stages
//   ASYNC  in   [BUS_WIDTH] asynchronous level inputs
//   SYNC   out  [BUS_WIDTH] synchronized outputs, driven by the last stages
// Optional macro BIT_SYNC_ASSERT_EN: adds an elaboration-time parameter check
// and a simulation assertion that SYNC never carries X/Z once the chains have
// been filled after reset. Hardware is identical with or without it.
// ---------------------------------------------------------------------------
module bit_sync
    import bit_sync_pkg::*;
#(
    parameter int NUM_STAGES = BIT_SYNC_DEF_STAGES,
    parameter int BUS_WIDTH  = BIT_SYNC_DEF_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] ASYNC,
    output logic [BUS_WIDTH-1:0] SYNC
);

    // One fully independent chain per bit.
    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_bit
        sync_chain #(
            .NUM_STAGES(NUM_STAGES)
        ) u_chain (
            .CLK(CLK),
            .RST(RST),
            .d_i(ASYNC[i]),
            .q_o(SYNC[i])
        );
    end

`ifdef BIT_SYNC_ASSERT_EN
    if (!bitSyncParamsLegal(NUM_STAGES, BUS_WIDTH)) begin : g_bad_params
        $fatal(1, "bit_sync: need NUM_STAGES >= %0d and BUS_WIDTH >= 1 (got %0d, %0d)",
               BIT_SYNC_MIN_STAGES, NUM_STAGES, BUS_WIDTH);
    end

    // Counts edges since reset release, saturating once every stage holds a
    // real sample; before that the outputs are reset zeros, not captured data.
    int settle_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            settle_q <= 0;
        end else if (settle_q < NUM_STAGES) begin
            settle_q <= settle_q + 1;
        end
    end

    a_sync_known : assert property (
        @(posedge CLK) disable iff (!RST)
        (settle_q >= NUM_STAGES) |-> !$isunknown(SYNC)
    );
`else
`endif

endmodule : bit_sync

// File: tb/tb_bit_sync.sv
// ---------------------------------------------------------------------------
// tb_bit_sync
// Self-checking bench for bit_sync. Three instances share one stimulus bus:
// the default build (5 stages, 6 bits) plus the sweep corners (2 stages,
// 1 bit) and (8 stages, 16 bits). A reference model keeps the history of
// values present on the bus at each rising edge since reset release; a DUT
// with N stages must show the value sampled N-1 edges ago, or 0 if fewer
// than N edges have occurred since release.
// ---------------------------------------------------------------------------
module tb_bit_sync;

    logic        clk;
    logic        rst;
    logic [15:0] asyncIn;
    logic [5:0]  syncA;
    logic [0:0]  syncB;
    logic [15:0] syncC;

    int checks   = 0;
    int failures = 0;

    // Reference history: newest sample at index 0.
    logic [15:0] hist[$];
    int          edgesSinceRelease = 0;

    bit_sync #(.NUM_STAGES(5), .BUS_WIDTH(6)) dutA (
        .CLK(clk), .RST(rst), .ASYNC(asyncIn[5:0]), .SYNC(syncA)
    );

    bit_sync #(.NUM_STAGES(2), .BUS_WIDTH(1)) dutB (
        .CLK(clk), .RST(rst), .ASYNC(asyncIn[0:0]), .SYNC(syncB)
    );

    bit_sync #(.NUM_STAGES(8), .BUS_WIDTH(16)) dutC (
        .CLK(clk), .RST(rst), .ASYNC(asyncIn), .SYNC(syncC)
    );

    // 10-unit clock with rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: record the bus at every rising edge; reset wipes history.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist.delete();
            edgesSinceRelease = 0;
        end else begin
            hist.push_front(asyncIn);
            if (hist.size() > 16) void'(hist.pop_back());
            edgesSinceRelease++;
        end
    end

    function automatic logic [31:0] expectedFor(input int n, input logic [15:0] mask);
        if (edgesSinceRelease >= n) return 32'(hist[n-1] & mask);
        return 32'd0;
    endfunction

    // The single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at t=%0t", tag, actual, expected, $time);
        end
    endtask

    // Advance to the next falling edge and compare all instances to the model.
    task automatic stepAndCompare();
        @(negedge clk);
        checkOutput("model_a", 32'(syncA), expectedFor(5, 16'h003F));
        checkOutput("model_b", 32'(syncB), expectedFor(2, 16'h0001));
        checkOutput("model_c", 32'(syncC), expectedFor(8, 16'hFFFF));
    endtask

    // Drive a new bus value (called at a falling edge) and run n cycles.
    task automatic applyStimulus(input logic [15:0] value, input int n);
        asyncIn = value;
        for (int k = 0; k < n; k++) stepAndCompare();
    endtask

    initial begin
        int pulseCycles;

        // Reset asserted with all inputs high: outputs must be 0 before any edge.
        rst     = 1'b0;
        asyncIn = 16'hFFFF;
        #2;
        checkOutput("reset_pre_edge_a", 32'(syncA), 32'd0);
        checkOutput("reset_pre_edge_c", 32'(syncC), 32'd0);

        // Still held through the first rising edge (t=5); we are now at t=10.
        stepAndCompare();
        checkOutput("reset_held_a", 32'(syncA), 32'd0);

        // Latency: release at t=10 with 6'b101011 on the bus.
        rst     = 1'b1;
        asyncIn = 16'hA52B;
        for (int e = 1; e <= 9; e++) begin
            stepAndCompare();
            if (e == 1) checkOutput("lat_b_1edge", 32'(syncB), 32'd0);
            if (e == 2) checkOutput("lat_b_2edge", 32'(syncB), 32'd1);
            if (e == 4) checkOutput("lat_a_4edge", 32'(syncA), 32'h00);
            if (e == 5) checkOutput("lat_a_5edge", 32'(syncA), 32'h2B);
            if (e == 7) checkOutput("lat_c_7edge", 32'(syncC), 32'h0000);
            if (e == 8) checkOutput("lat_c_8edge", 32'(syncC), 32'hA52B);
        end

        // Per-bit independence: only bit 2 rises.
        applyStimulus(16'h0000, 10);
        asyncIn = 16'h0004;
        for (int e = 1; e <= 5; e++) begin
            stepAndCompare();
            if (e == 4) checkOutput("indep_4edge", 32'(syncA), 32'h00);
            if (e == 5) checkOutput("indep_5edge", 32'(syncA), 32'h04);
        end
        applyStimulus(16'h0004, 4);

        // Pulse fidelity: 3-cycle pulse 6'b010000 must reappear 3 cycles wide.
        applyStimulus(16'h0000, 10);
        applyStimulus(16'h0010, 3);
        asyncIn     = 16'h0000;
        pulseCycles = 0;
        for (int k = 0; k < 12; k++) begin
            stepAndCompare();
            if (syncA == 6'b010000) pulseCycles++;
        end
        checkOutput("pulse_width", 32'(pulseCycles), 32'd3);

        // Mid-operation reset two edges after 6'b110011 appears.
        applyStimulus(16'h0033, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst_immediate", 32'(syncA), 32'd0);
        stepAndCompare();
        rst = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            stepAndCompare();
            if (e == 4) checkOutput("midrst_4edge", 32'(syncA), 32'h00);
            if (e == 5) checkOutput("midrst_5edge", 32'(syncA), 32'h33);
        end

        // Randomized traffic, bus changing only away from rising edges.
        for (int k = 0; k < 200; k++) begin
            applyStimulus(16'($urandom()), 1 + int'($urandom_range(2, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bit_sync
